// File: rtl/seq_alu_core.sv
// Multi-cycle unsigned ALU (add/sub/mul/div/mod) with start/busy/done handshake; optional status flags via SEQ_ALU_STATUS_EN.
// Latency: ADD/SUB/invalid done one cycle after acceptance; MUL/DIV/MOD busy W cycles, done on the next.
// Backpressure: start is ignored while busy; a new op may be accepted in the DONE cycle (back-to-back).
module seq_alu_core #(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ctrl,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic [2:0]       flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [4:0] CNT_LAST = 5'(W - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       cnt_q, cnt_d;
    // shift-add multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    // restoring divider: partial remainder, quotient (starts as dividend), divisor
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvsr_q, dvsr_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2*W-1:0]   mul_step;
    logic [W:0]       rem_shift;
    logic [W-1:0]     rem_sub;
    logic             div_ok;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     quo_next;
    logic [2*W-1:0]   fast_res;
    logic [2*W-1:0]   calc_res;

`ifdef SEQ_ALU_STATUS_EN
    logic [2:0]       flags_q, flags_d;
`endif

    // one iteration of shift-add and restoring division, plus single-cycle op results
    always_comb begin
        mul_step  = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
        rem_shift = {rem_q, quo_q[W-1]};
        div_ok    = (rem_shift >= {1'b0, dvsr_q});
        // when the trial subtraction succeeds the difference is below the divisor, so W bits suffice
        rem_sub   = rem_shift[W-1:0] - dvsr_q;
        rem_next  = div_ok ? rem_sub : rem_shift[W-1:0];
        quo_next  = {quo_q[W-2:0], div_ok};

        case (ctrl)
            OP_ADD:  fast_res = {{W{1'b0}}, a} + {{W{1'b0}}, b};
            OP_SUB:  fast_res = {{W{1'b0}}, a} - {{W{1'b0}}, b};
            default: fast_res = {(2*W){1'b0}};
        endcase

        case (op_q)
            OP_MUL:  calc_res = mul_step;
            OP_DIV:  calc_res = {{W{1'b0}}, quo_next};
            default: calc_res = {{W{1'b0}}, rem_next};
        endcase
    end

    // next-state and datapath update for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
`ifdef SEQ_ALU_STATUS_EN
        flags_d  = flags_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d = ctrl;
                    if (ctrl == OP_MUL || ctrl == OP_DIV || ctrl == OP_MOD) begin
                        state_d  = S_CALC;
                        cnt_d    = 5'd0;
                        acc_d    = {(2*W){1'b0}};
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                        rem_d    = {W{1'b0}};
                        quo_d    = a;
                        dvsr_d   = b;
                    end else begin
                        state_d  = S_DONE;
                        result_d = fast_res;
`ifdef SEQ_ALU_STATUS_EN
                        flags_d  = {1'b0, (ctrl == OP_SUB) && (a < b), fast_res == {(2*W){1'b0}}};
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d    = cnt_q + 5'd1;
                acc_d    = mul_step;
                mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                rem_d    = rem_next;
                quo_d    = quo_next;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = calc_res;
`ifdef SEQ_ALU_STATUS_EN
                    flags_d  = {(op_q != OP_MUL) && (dvsr_q == {W{1'b0}}), 1'b0,
                                calc_res == {(2*W){1'b0}}};
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // state registers; synchronous reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= 5'd0;
            acc_q    <= {(2*W){1'b0}};
            mcand_q  <= {(2*W){1'b0}};
            mplier_q <= {W{1'b0}};
            rem_q    <= {W{1'b0}};
            quo_q    <= {W{1'b0}};
            dvsr_q   <= {W{1'b0}};
            result_q <= {(2*W){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_STATUS_EN
            flags_q  <= 3'b000;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_ALU_STATUS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef SEQ_ALU_STATUS_EN
    assign flags  = flags_q;
`else
    assign flags  = 3'b000;
`endif

endmodule
